// File: rtl/alu_result_decoder_pkg.sv
// Package calc_pkg: shared constants for the ALU result decoder slice.
//  - MAX_MAG            largest magnitude that fits on four decimal digits
//  - ST_*               decoder FSM state encoding
//  - SEG_MINUS/BLANK    active-low segment patterns {g..a}
//  - bcd_to_seg()       BCD digit to active-low 7-segment pattern
package calc_pkg;

  localparam int MAX_MAG = 9999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles render blank rather than a hex glyph.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/alu_result_decoder_if.sv
// Interface between the calculator ALU and the result decoder.
//  in_valid/in_ready/in_value/in_overflow : result handshake (ALU -> decoder)
//  out_valid/bcd/neg/err                  : converted result (decoder -> consumers)
//  master: ALU/consumer side, slave: decoder side.
interface alu_result_decoder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             in_overflow;
  logic             out_valid;
  logic [15:0]      bcd;
  logic             neg;
  logic             err;

  modport master (
    output in_valid, in_value, in_overflow,
    input  in_ready, out_valid, bcd, neg, err
  );

  modport slave (
    input  in_valid, in_value, in_overflow,
    output in_ready, out_valid, bcd, neg, err
  );
endinterface

// File: rtl/seg_scan_4digit.sv
// Four-digit multiplexed 7-segment scanner (active-low segments and anodes).
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  bcd[15:0]    held {thousands,hundreds,tens,ones}
//  neg, err     held sign / not-displayable flags
//  seg[6:0]     segments {g..a}, active-low
//  an[3:0]      digit enables, active-low, an[3] = leftmost
// Build option LEADING_ZERO_BLANK_EN: blank leading zeros and place '-' just
// left of the most significant non-zero digit; otherwise all four digits show
// and the sign is not displayed.
module seg_scan_4digit
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  input  logic        neg,
  input  logic        err,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       idx_r;
  logic             tick_s;
  logic [3:0]       nib_s;
  logic [6:0]       seg_next_s;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;

  assign tick_s = (div_r == DIV_W'(SCAN_DIV - 1));
  assign nib_s  = bcd[{idx_r, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lead_s;
  logic [3:0] minus_pos_s;
  // lead_s[i]: digit i and everything left of it is zero (ones never blank).
  assign lead_s[3] = (bcd[15:12] == 4'd0);
  assign lead_s[2] = lead_s[3] & (bcd[11:8] == 4'd0);
  assign lead_s[1] = lead_s[2] & (bcd[7:4] == 4'd0);
  assign lead_s[0] = 1'b0;
  // Sign sits on the lowest blanked position; none exists for |value| >= 1000.
  assign minus_pos_s = lead_s & ~{lead_s[2:0], 1'b0};

  // Select the pattern for the digit being scanned.
  always_comb begin
    seg_next_s = bcd_to_seg(nib_s);
    if (err) begin
      seg_next_s = SEG_MINUS;
    end else if (neg && minus_pos_s[idx_r]) begin
      seg_next_s = SEG_MINUS;
    end else if (lead_s[idx_r]) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = bcd_to_seg(nib_s);
    end
  end
`else
  logic unused_neg_s;
  assign unused_neg_s = neg;

  // Select the pattern for the digit being scanned.
  always_comb begin
    seg_next_s = bcd_to_seg(nib_s);
    if (err) begin
      seg_next_s = SEG_MINUS;
    end else begin
      seg_next_s = bcd_to_seg(nib_s);
    end
  end
`endif

  // Free-running divider and digit index, registered segment/anode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
      idx_r <= 2'd0;
      seg_r <= bcd_to_seg(4'h0);
      an_r  <= 4'b1110;
    end else begin
      if (tick_s) begin
        div_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
      seg_r <= seg_next_s;
      an_r  <= ~(4'b0001 << idx_r);
    end
  end

  assign seg = seg_r;
  assign an  = an_r;
endmodule

// File: rtl/alu_result_decoder.sv
// ALU result decoder: accepts a signed result + overflow flag, converts the
// magnitude to four BCD digits by serial double-dabble, holds the result and
// drives a 4-digit multiplexed 7-segment display.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  bus          alu_result_decoder_if.slave (in_* handshake, out_valid/bcd/neg/err)
//  seg[6:0]     segments {g..a}, active-low
//  an[3:0]      digit enables, active-low, an[3] = leftmost
// Build option LEADING_ZERO_BLANK_EN (display only, see seg_scan_4digit).
module alu_result_decoder
  import calc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAG_BITS = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_decoder_if.slave bus,
  output logic [6:0]          seg,
  output logic [3:0]          an
);
  localparam int CNT_W = $clog2(MAG_BITS);

  logic [1:0]          state_r;
  logic [WIDTH-1:0]    value_r;
  logic                ovf_r;
  logic [15:0]         work_bcd_r;
  logic [MAG_BITS-1:0] work_mag_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                neg_pend_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [15:0]         bcd_r;
  logic                neg_r;
  logic                err_r;

  logic [WIDTH:0]      ext_s;
  logic [WIDTH:0]      mag_s;
  logic                load_err_s;
  logic [15:0]         adj_s;
  logic [15:0]         shift_bcd_s;
  logic [MAG_BITS-1:0] shift_mag_s;

  // One extra bit keeps the magnitude of the most negative value representable.
  assign ext_s      = {value_r[WIDTH-1], value_r};
  assign mag_s      = value_r[WIDTH-1] ? ((WIDTH+1)'(0) - ext_s) : ext_s;
  assign load_err_s = ovf_r | (mag_s > (WIDTH+1)'(MAX_MAG));

  // Double-dabble correction: add 3 to every nibble >= 5 before shifting.
  always_comb begin
    adj_s = work_bcd_r;
    for (int i = 0; i < 4; i++) begin
      if (work_bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = work_bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = work_bcd_r[4*i +: 4];
      end
    end
  end

  assign shift_bcd_s = {adj_s[14:0], work_mag_r[MAG_BITS-1]};
  assign shift_mag_s = {work_mag_r[MAG_BITS-2:0], 1'b0};

  // Conversion FSM; held outputs are written on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      value_r     <= '0;
      ovf_r       <= 1'b0;
      work_bcd_r  <= 16'h0000;
      work_mag_r  <= '0;
      cnt_r       <= '0;
      neg_pend_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bcd_r       <= 16'h0000;
      neg_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            value_r    <= bus.in_value;
            ovf_r      <= bus.in_overflow;
            in_ready_r <= 1'b0;
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_err_s) begin
            bcd_r       <= 16'hFFFF;
            neg_r       <= 1'b0;
            err_r       <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            work_bcd_r <= 16'h0000;
            work_mag_r <= mag_s[MAG_BITS-1:0];
            neg_pend_r <= value_r[WIDTH-1];
            cnt_r      <= '0;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_bcd_r <= shift_bcd_s;
          work_mag_r <= shift_mag_s;
          cnt_r      <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(MAG_BITS - 1)) begin
            bcd_r       <= shift_bcd_s;
            neg_r       <= neg_pend_r;
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.bcd       = bcd_r;
  assign bus.neg       = neg_r;
  assign bus.err       = err_r;

  seg_scan_4digit #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .bcd   (bcd_r),
    .neg   (neg_r),
    .err   (err_r),
    .seg   (seg),
    .an    (an)
  );
endmodule

// File: tb/tb_alu_result_decoder.sv
// Directed testbench for alu_result_decoder (SCAN_DIV=4 for a fast scan).
module tb_alu_result_decoder;
  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] an;
  int         total;
  int         bad;

  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_M = 7'b0111111;
  localparam logic [6:0] S_B = 7'b1111111;

  alu_result_decoder_if #(.WIDTH(16)) bus ();

  alu_result_decoder #(.WIDTH(16), .MAG_BITS(14), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .seg   (seg),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one result; lat = negedges from transfer cycle to out_valid, -1 on timeout.
  task automatic do_transfer(input logic [15:0] v, input logic ovf, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    bus.in_valid    = 1'b1;
    bus.in_value    = v;
    bus.in_overflow = ovf;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 7;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL rst_bcd: got %h want 0000", bus.bcd); end
    if (bus.neg !== 1'b0) begin bad++; $display("FAIL rst_neg: got %b want 0", bus.neg); end
    if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
    if (an !== 4'b1110) begin bad++; $display("FAIL rst_an: got %b want 1110", an); end
    if (seg !== S_0) begin bad++; $display("FAIL rst_seg: got %b want %b", seg, S_0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_convert();
    logic [15:0] vals  [4];
    logic [15:0] ebcd  [4];
    logic        eneg  [4];
    int lat;
    // 1234, -9999, 0, +9999
    vals = '{16'h04D2, 16'hD8F1, 16'h0000, 16'h270F};
    ebcd = '{16'h1234, 16'h9999, 16'h0000, 16'h9999};
    eneg = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_transfer(vals[k], 1'b0, lat);
      total += 5;
      if (lat != 16) begin bad++; $display("FAIL conv%0d_latency: got %0d want 16", k, lat); end
      if (bus.bcd !== ebcd[k]) begin bad++; $display("FAIL conv%0d_bcd: got %h want %h", k, bus.bcd, ebcd[k]); end
      if (bus.neg !== eneg[k]) begin bad++; $display("FAIL conv%0d_neg: got %b want %b", k, bus.neg, eneg[k]); end
      if (bus.err !== 1'b0) begin bad++; $display("FAIL conv%0d_err: got %b want 0", k, bus.err); end
      @(negedge clk);
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL conv%0d_pulse: got %b want 0", k, bus.out_valid); end
    end
  endtask

  task automatic test_error();
    logic [15:0] vals [3];
    logic        ovfs [3];
    int lat;
    int not_minus;
    logic [3:0] seen;
    // overflow flag, 10000, -32768
    vals = '{16'h0005, 16'h2710, 16'h8000};
    ovfs = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_transfer(vals[k], ovfs[k], lat);
      total += 4;
      if (lat != 2) begin bad++; $display("FAIL err%0d_latency: got %0d want 2", k, lat); end
      if (bus.bcd !== 16'hFFFF) begin bad++; $display("FAIL err%0d_bcd: got %h want FFFF", k, bus.bcd); end
      if (bus.neg !== 1'b0) begin bad++; $display("FAIL err%0d_neg: got %b want 0", k, bus.neg); end
      if (bus.err !== 1'b1) begin bad++; $display("FAIL err%0d_err: got %b want 1", k, bus.err); end
    end
    repeat (2) @(negedge clk);
    not_minus = 0;
    seen = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      if (seg !== S_M) not_minus++;
      seen = seen | ~an;
      @(negedge clk);
    end
    total += 2;
    if (not_minus != 0) begin bad++; $display("FAIL err_display: got %0d non-minus samples want 0", not_minus); end
    if (seen !== 4'hF) begin bad++; $display("FAIL err_scan_digits: got %b want 1111", seen); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic [15:0] ebcd [3];
    logic        eneg [3];
    int acc_cyc [3];
    int n_acc, n_pulse;
    vals = '{16'h0007, 16'h0064, 16'hFFFF};
    ebcd = '{16'h0007, 16'h0100, 16'h0001};
    eneg = '{1'b0, 1'b0, 1'b1};
    acc_cyc = '{0, 0, 0};
    n_acc = 0;
    n_pulse = 0;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_value    = vals[0];
    bus.in_overflow = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (bus.out_valid) begin
        total++;
        if (n_pulse >= 3) begin
          bad++; $display("FAIL b2b_extra_pulse: got pulse %0d want at most 3", n_pulse + 1);
        end else if (bus.bcd !== ebcd[n_pulse] || bus.neg !== eneg[n_pulse]) begin
          bad++; $display("FAIL b2b_result%0d: got %h/%b want %h/%b", n_pulse, bus.bcd, bus.neg, ebcd[n_pulse], eneg[n_pulse]);
        end
        n_pulse++;
      end
      if (bus.in_valid && bus.in_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc >= 3) bus.in_valid = 1'b0;
      else if (n_acc > 0) bus.in_value = vals[n_acc];
    end
    total += 4;
    if (n_acc != 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", n_acc); end
    if (n_pulse != 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", n_pulse); end
    if (acc_cyc[1] - acc_cyc[0] != 17) begin bad++; $display("FAIL b2b_gap1: got %0d want 17", acc_cyc[1] - acc_cyc[0]); end
    if (acc_cyc[2] - acc_cyc[1] != 17) begin bad++; $display("FAIL b2b_gap2: got %0d want 17", acc_cyc[2] - acc_cyc[1]); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    do_transfer(16'h04D2, 1'b0, lat);
    @(negedge clk);
    // 5678, aborted while shifting
    bus.in_valid    = 1'b1;
    bus.in_value    = 16'h162E;
    bus.in_overflow = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total += 5;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL midrst_bcd: got %h want 0000", bus.bcd); end
    if (bus.err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", bus.err); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    if (an !== 4'b1110) begin bad++; $display("FAIL midrst_an: got %b want 1110", an); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    total += 2;
    if (pulses != 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d want 0", pulses); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_display();
    int lat;
    int g;
    logic [3:0] ean  [4];
    logic [6:0] eseg [4];
    do_transfer(16'hFFD6, 1'b0, lat);  // -42
    total += 2;
    if (lat != 16) begin bad++; $display("FAIL disp_latency: got %0d want 16", lat); end
    if (bus.bcd !== 16'h0042 || bus.neg !== 1'b1) begin bad++; $display("FAIL disp_result: got %h/%b want 0042/1", bus.bcd, bus.neg); end
    ean = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
`ifdef LEADING_ZERO_BLANK_EN
    eseg = '{S_4, S_M, S_B, S_2};
`else
    eseg = '{S_4, S_0, S_0, S_2};
`endif
    g = 0;
    while (an === 4'b1101 && g < 20) begin @(negedge clk); g++; end
    while (an !== 4'b1101 && g < 40) begin @(negedge clk); g++; end
    total++;
    if (an !== 4'b1101) begin
      bad++; $display("FAIL disp_sync: got %b want 1101", an);
    end
    for (int k = 0; k < 4; k++) begin
      total += 2;
      if (an !== ean[k]) begin bad++; $display("FAIL disp_an%0d: got %b want %b", k, an, ean[k]); end
      if (seg !== eseg[k]) begin bad++; $display("FAIL disp_seg%0d: got %b want %b", k, seg, eseg[k]); end
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.in_valid    = 1'b0;
    bus.in_value    = 16'h0000;
    bus.in_overflow = 1'b0;
    test_reset();
    test_convert();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_display();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
